// File: rtl/rvfi_check_pkg.sv
// Shared types for the RVFI register-history checker: FSM states, history
// entry layout and the check_fail bit codes.
package rvfi_check_pkg;

  localparam int ORDER_W  = 64;
  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_UNKNOWN = 2'd2,
    ST_DONE    = 2'd3
  } chk_state_t;

  // Data is held at the widest supported XLEN; narrower cores zero-extend.
  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [MAX_XLEN-1:0] data;
  } hist_entry_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_RS1  = 2'b01;
  localparam logic [1:0] FC_RS2  = 2'b10;

endpackage

// File: rtl/rvfi_reg_hist_check_if.sv
// Per-channel RVFI retire bus plus the rollback side channel, as seen by the
// register-history checker.
interface rvfi_reg_hist_check_if #(
  parameter int XLEN = 32,
  parameter int NRET = 2
);
  logic [NRET-1:0]      rvfi_valid;
  logic [64*NRET-1:0]   rvfi_order;
  logic [5*NRET-1:0]    rvfi_rd_addr;
  logic [5*NRET-1:0]    rvfi_rs1_addr;
  logic [5*NRET-1:0]    rvfi_rs2_addr;
  logic [XLEN*NRET-1:0] rvfi_rd_wdata;
  logic [XLEN*NRET-1:0] rvfi_rs1_rdata;
  logic [XLEN*NRET-1:0] rvfi_rs2_rdata;
  logic                 rvfi_rollback_valid;
  logic [63:0]          rvfi_rollback_order;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_rd_addr, rvfi_rs1_addr, rvfi_rs2_addr,
    output rvfi_rd_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata,
    output rvfi_rollback_valid, rvfi_rollback_order
  );

  modport slave (
    input rvfi_valid, rvfi_order, rvfi_rd_addr, rvfi_rs1_addr, rvfi_rs2_addr,
    input rvfi_rd_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata,
    input rvfi_rollback_valid, rvfi_rollback_order
  );
endinterface

// File: rtl/rvfi_order_hist.sv
// Circular LIFO of {order, data} writes: rollback pops from the newest end,
// then up to NRET pushes are applied in ascending order in the same cycle.
module rvfi_order_hist
  import rvfi_check_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rb_valid,
  input  logic [ORDER_W-1:0]  rb_order,
  input  logic [NRET-1:0]     push_valid,
  input  hist_entry_t         push_entry [NRET],
  output logic                nonempty_next,
  output logic [MAX_XLEN-1:0] newest_data_next,
  output logic                rb_emptied,
  output logic                lost_oldest
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  hist_entry_t        ent_reg  [DEPTH];
  hist_entry_t        ent_next [DEPTH];
  logic [AW-1:0]      head_reg, head_next;
  logic [CW-1:0]      count_reg, count_next;
  logic               lost_reg, lost_next;

  logic               popping;
  logic [AW-1:0]      idx;
  logic               have_last;
  logic [ORDER_W-1:0] last_order;
  logic               found;
  hist_entry_t        sel;

  always_comb begin
    ent_next   = ent_reg;
    head_next  = head_reg;
    count_next = count_reg;
    lost_next  = lost_reg;
    popping    = rb_valid;
    idx        = '0;
    have_last  = 1'b0;
    last_order = '0;
    found      = 1'b0;
    sel        = '0;

    // Orders rise from oldest to newest, so the entries to discard form a
    // contiguous run at the head.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_reg - AW'(i);
      if (popping && (CW'(i) < count_reg) && (ent_reg[idx].order >= rb_order)) begin
        head_next  = head_next - AW'(1);
        count_next = count_next - CW'(1);
      end else begin
        popping = 1'b0;
      end
    end
    rb_emptied = rb_valid && (count_reg != '0) && (count_next == '0);

    have_last  = (count_next != '0);
    last_order = ent_reg[head_next].order;

    // Each pass takes the smallest order still above the newest one; ties go
    // to the highest channel, and the losers then fail the "above" test.
    for (int k = 0; k < NRET; k++) begin
      found = 1'b0;
      sel   = '0;
      for (int c = 0; c < NRET; c++) begin
        if (push_valid[c] && (!have_last || (push_entry[c].order > last_order)) &&
            (!found || (push_entry[c].order <= sel.order))) begin
          found = 1'b1;
          sel   = push_entry[c];
        end
      end
      if (found) begin
        head_next           = head_next + AW'(1);
        ent_next[head_next] = sel;
        if (count_next == CW'(DEPTH)) begin
          lost_next = 1'b1;
        end else begin
          count_next = count_next + CW'(1);
        end
        have_last  = 1'b1;
        last_order = sel.order;
      end
    end

    nonempty_next    = (count_next != '0);
    newest_data_next = ent_next[head_next].data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i] <= '0;
      end
      head_reg  <= '0;
      count_reg <= '0;
      lost_reg  <= 1'b0;
    end else begin
      ent_reg   <= ent_next;
      head_reg  <= head_next;
      count_reg <= count_next;
      lost_reg  <= lost_next;
    end
  end

  assign lost_oldest = lost_reg;

endmodule

// File: rtl/rvfi_reg_hist_check.sv
// Checks that rs1/rs2 reads of one tracked register by the instruction at
// insn_order match the most recent earlier retired write to that register.
module rvfi_reg_hist_check
  import rvfi_check_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NRET        = 2,
  parameter int CHANNEL_IDX = 0,
  parameter int DEPTH       = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  check,
  input  logic [63:0]           insn_order,
  input  logic [4:0]            register_index,
  rvfi_reg_hist_check_if.slave  rvfi,
  output logic                  check_done,
  output logic [1:0]            check_fail,
  output logic                  shadow_known
);

  logic [NRET-1:0]      cand_valid;
  hist_entry_t          cand_entry [NRET];
  logic                 hist_nonempty_next;
  logic [MAX_XLEN-1:0]  shadow_next;
  logic                 rb_emptied;
  logic                 lost_oldest;

  chk_state_t           state_reg, state_next;
  logic                 done_next;
  logic [1:0]           fail_next;
  logic [1:0]           fail_bits;

  logic [4:0]           rs1_addr, rs2_addr;
  logic [MAX_XLEN-1:0]  rs1_data, rs2_data;
  logic                 unused_rs;

  genvar gi;
  generate
    for (gi = 0; gi < NRET; gi++) begin : g_cand
      logic [63:0] ord;
      assign ord = rvfi.rvfi_order[64*gi +: 64];
      assign cand_valid[gi] = rvfi.rvfi_valid[gi] && (ord < insn_order) &&
                              (rvfi.rvfi_rd_addr[5*gi +: 5] == register_index) &&
                              (register_index != 5'd0) &&
                              !(rvfi.rvfi_rollback_valid && (ord >= rvfi.rvfi_rollback_order));
      assign cand_entry[gi] = '{order: ord,
                                data:  MAX_XLEN'(rvfi.rvfi_rd_wdata[XLEN*gi +: XLEN])};
    end
  endgenerate

  rvfi_order_hist #(
    .NRET  (NRET),
    .DEPTH (DEPTH)
  ) u_hist (
    .clock            (clock),
    .reset            (reset),
    .rb_valid         (rvfi.rvfi_rollback_valid),
    .rb_order         (rvfi.rvfi_rollback_order),
    .push_valid       (cand_valid),
    .push_entry       (cand_entry),
    .nonempty_next    (hist_nonempty_next),
    .newest_data_next (shadow_next),
    .rb_emptied       (rb_emptied),
    .lost_oldest      (lost_oldest)
  );

  assign rs1_addr = rvfi.rvfi_rs1_addr[5*CHANNEL_IDX +: 5];
  assign rs2_addr = rvfi.rvfi_rs2_addr[5*CHANNEL_IDX +: 5];
  assign rs1_data = MAX_XLEN'(rvfi.rvfi_rs1_rdata[XLEN*CHANNEL_IDX +: XLEN]);
  assign rs2_data = MAX_XLEN'(rvfi.rvfi_rs2_rdata[XLEN*CHANNEL_IDX +: XLEN]);

  // Source operands of the other channels are never examined.
  assign unused_rs = ^{rvfi.rvfi_rs1_addr, rvfi.rvfi_rs2_addr,
                       rvfi.rvfi_rs1_rdata, rvfi.rvfi_rs2_rdata};

  // Compare against the history as it stands after this cycle's rollback
  // and the older same-cycle writes from the other channels.
  always_comb begin
    fail_bits = FC_NONE;
    if (register_index == 5'd0) begin
      if ((rs1_addr == 5'd0) && (rs1_data != '0)) fail_bits = fail_bits | FC_RS1;
      if ((rs2_addr == 5'd0) && (rs2_data != '0)) fail_bits = fail_bits | FC_RS2;
    end else if (hist_nonempty_next) begin
      if ((rs1_addr == register_index) && (rs1_data != shadow_next)) fail_bits = fail_bits | FC_RS1;
      if ((rs2_addr == register_index) && (rs2_data != shadow_next)) fail_bits = fail_bits | FC_RS2;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = check_done;
    fail_next  = check_fail;
    case (state_reg)
      ST_IDLE, ST_TRACK, ST_UNKNOWN: begin
        if (check) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
          fail_next  = check_fail | fail_bits;
        end else if (hist_nonempty_next) begin
          state_next = ST_TRACK;
        end else if (rb_emptied) begin
          state_next = lost_oldest ? ST_UNKNOWN : ST_IDLE;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      check_done   <= 1'b0;
      check_fail   <= FC_NONE;
      shadow_known <= 1'b0;
    end else begin
      state_reg    <= state_next;
      check_done   <= done_next;
      check_fail   <= fail_next;
      shadow_known <= hist_nonempty_next;
    end
  end

`ifdef FORMAL
  always @(posedge clock) begin
    if (reset && check) begin
      assume (rvfi.rvfi_valid[CHANNEL_IDX]);
      assume (rvfi.rvfi_order[64*CHANNEL_IDX +: 64] == insn_order);
    end
    if (reset) begin
      assert (check_fail == FC_NONE);
    end
  end
`endif

endmodule
